nes_joypad_serializer: RTL and testbench
========================================

// Module: nes_joypad_serializer
// PURPOSE
//   NES-side end of the joystick path. Takes the 8-bit parallel button states
//   (player 0/1, active-high, bit order {R,L,D,U,Start,Select,B,A}) produced by
//   the USB HID report decoders and presents them to the NES CPU as two
//   CD4021-style serial controller ports at $4016/$4017.
//   Decoded CPU-bus events drive it: a strobe write and read pulses.
//   It returns one serial bit per port, as a real joypad shift register does.
// PARAMETERS
//   C_FILL_BIT    1  value shifted in at MSB; returned after the 8th read
//   C_BTN_ACTLOW  0  1 = invert i_btn0/i_btn1 before use (active-low sources)
// PORTS
//   i_clk         in   1  single clock; all logic on posedge
//   i_reset       in   1  synchronous, active-high reset
//   i_btn0        in   8  player 0 button state, {R,L,D,U,Start,Select,B,A}
//   i_btn1        in   8  player 1 button state, same order
//   i_wr_strobe   in   1  1-cycle pulse: CPU write to $4016
//   i_wr_data     in   1  data bit 0 of that write (new strobe level)
//   i_rd0         in   1  1-cycle pulse: CPU read of $4016 (port 0)
//   i_rd1         in   1  1-cycle pulse: CPU read of $4017 (port 1)
//   o_rd_data0    out  1  current serial bit, port 0
//   o_rd_data1    out  1  current serial bit, port 1
//   o_latched     out  1  1-cycle pulse when a snapshot is latched (strobe 1->0)
// BEHAVIOUR
//   - State per port: 8-bit shift reg R_shN; R_strobe is shared by both ports.
//   - Reset: R_strobe=0, R_sh0=R_sh1=8'hFF if C_FILL_BIT else 8'h00, o_latched=0.
//     o_rd_dataN therefore reads C_FILL_BIT after reset.
//   - o_rd_dataN = R_shN[0], driven straight from a flop with no comb path
//     from the inputs. The CPU samples it in the same cycle as i_rdN.
//     That cycle returns the pre-shift bit.
//   - Strobe write: on i_wr_strobe, R_strobe <= i_wr_data at the next edge.
//   - Strobe high (R_strobe=1): every cycle R_shN <= btnN (after optional
//     inversion). Reads return the live A bit and never shift.
//   - Falling strobe: i_wr_strobe with i_wr_data=0 while R_strobe=1.
//     This loads R_shN <= btnN once and pulses o_latched for exactly 1 cycle.
//     A 0-write while R_strobe=0 is ignored: no reload, no pulse.
//   - Strobe low: i_rdN => R_shN <= {C_FILL_BIT, R_shN[7:1]} at the next edge.
//     Order out is A,B,Select,Start,U,D,L,R, then C_FILL_BIT forever.
//     There is no counter wrap: the fill saturates.
//   - i_rd0 and i_rd1 are independent. Both may assert in the same cycle and
//     each port shifts.
//   - Same-cycle write and read: a write that sets or keeps the strobe high
//     wins, so the read does not shift. A falling-strobe write with a read
//     loads the snapshot; the read returns the old R_shN[0] and does not shift.
//     A 0-write with R_strobe=0 does not block the read's shift.
//   - A read pulse longer than 1 cycle shifts once per cycle. The bus decoder
//     guarantees single-cycle pulses.
//   - i_btnN may change at any time; only the strobe-high reload or the
//     falling-strobe load samples it.
//   - i_reset mid-sequence: returns to the reset state at the next edge; the
//     next read returns C_FILL_BIT until a new strobe cycle occurs.
// TESTING
//   1 reset; no strobe; 10 reads on port 0 -> o_rd_data0=1 on every read,
//     o_latched never asserted.
//   2 i_btn0=8'b1000_0101 (R,Select,A); write 1 then 0; 10 reads ->
//     o_latched 1 pulse; bits 1,0,1,0,0,0,0,1,1,1.
//   3 strobe held 1, i_btn0 A toggled 0/1 every 3 cycles, 4 reads ->
//     o_rd_data0 tracks A with 1-cycle lag; no shifting.
//   4 i_btn0=8'h01, i_btn1=8'h80, latch, 8 reads with i_rd0 and i_rd1
//     coincident -> port0 1,0,0,0,0,0,0,0 and port1 0,0,0,0,0,0,0,1.
//   5 after 3 reads, a write of 0 in the same cycle as a read (R_strobe=0) ->
//     the read still shifts, 4th bit correct, no o_latched; a write of 1 plus
//     a read -> no shift.
//   6 after 4 reads, assert i_reset 1 cycle -> next read 1 (fill); a fresh
//     strobe 1->0 restores the correct A-first sequence.

Source files
------------

// File: rtl/nes_joypad_serializer.sv
// Purpose: two CD4021-style NES controller ports ($4016/$4017) fed from parallel USB-decoded buttons.
// Latency: a strobe write or read pulse takes effect at the next edge; the serial bits come straight from flops.
// Backpressure: none; the CPU bus events are single-cycle pulses that are always accepted.
//
// Ports:
//   i_clk, i_reset            single clock, synchronous active-high reset
//   i_btn0, i_btn1            parallel button state {R,L,D,U,Start,Select,B,A}
//   i_wr_strobe, i_wr_data    CPU write to $4016 and its bit 0 (new strobe level)
//   i_rd0, i_rd1              CPU read pulses for $4016 / $4017
//   o_rd_data0, o_rd_data1    current serial bit of each port (registered)
//   o_latched                 1-cycle pulse when a snapshot is taken on strobe 1->0
module nes_joypad_serializer #(
    parameter logic C_FILL_BIT   = 1'b1,
    parameter bit   C_BTN_ACTLOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_btn0,
    input  logic [7:0] i_btn1,
    input  logic       i_wr_strobe,
    input  logic       i_wr_data,
    input  logic       i_rd0,
    input  logic       i_rd1,
    output logic       o_rd_data0,
    output logic       o_rd_data1,
    output logic       o_latched
);

    logic       r_strobe;
    logic [7:0] r_sh0;
    logic [7:0] r_sh1;
    logic       r_latched;

    logic [7:0] btn0_eff;
    logic [7:0] btn1_eff;
    logic       set_wr;
    logic       fall_wr;
    logic       shift0;
    logic       shift1;

    always_comb begin
        btn0_eff = C_BTN_ACTLOW ? ~i_btn0 : i_btn0;
        btn1_eff = C_BTN_ACTLOW ? ~i_btn1 : i_btn1;

        // A write that sets or keeps the strobe high takes priority over a
        // same-cycle read, so that read must not shift.
        set_wr  = i_wr_strobe & i_wr_data;

        // Falling edge of the strobe: only a 0-write while the strobe is high.
        fall_wr = i_wr_strobe & ~i_wr_data & r_strobe;

        // While the strobe is high the register is reloaded every cycle
        // (including the falling-strobe cycle), so reads never shift then.
        shift0  = ~r_strobe & i_rd0 & ~set_wr;
        shift1  = ~r_strobe & i_rd1 & ~set_wr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_strobe  <= 1'b0;
            r_sh0     <= {8{C_FILL_BIT}};
            r_sh1     <= {8{C_FILL_BIT}};
            r_latched <= 1'b0;
        end else begin
            if (i_wr_strobe) begin
                r_strobe <= i_wr_data;
            end

            r_latched <= fall_wr;

            if (r_strobe) begin
                r_sh0 <= btn0_eff;
            end else if (shift0) begin
                r_sh0 <= {C_FILL_BIT, r_sh0[7:1]};
            end

            if (r_strobe) begin
                r_sh1 <= btn1_eff;
            end else if (shift1) begin
                r_sh1 <= {C_FILL_BIT, r_sh1[7:1]};
            end
        end
    end

    // The CPU samples in the read cycle itself, so the pre-shift bit is what it sees.
    assign o_rd_data0 = r_sh0[0];
    assign o_rd_data1 = r_sh1[0];
    assign o_latched  = r_latched;

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Purpose: self-checking bench for nes_joypad_serializer (index-based reference model plus literal read sequences).
// Latency: model predictions are aligned to the DUT's one-edge register latency.
// Backpressure: not applicable; the bench drives single-cycle bus pulses.
module tb_nes_joypad_serializer;

    localparam logic FILL = 1'b1;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_btn0 = 8'h00;
    logic [7:0] i_btn1 = 8'h00;
    logic       i_wr_strobe = 1'b0;
    logic       i_wr_data = 1'b0;
    logic       i_rd0 = 1'b0;
    logic       i_rd1 = 1'b0;
    logic       o_rd_data0;
    logic       o_rd_data1;
    logic       o_latched;

    nes_joypad_serializer #(
        .C_FILL_BIT   (1'b1),
        .C_BTN_ACTLOW (1'b0)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_btn0      (i_btn0),
        .i_btn1      (i_btn1),
        .i_wr_strobe (i_wr_strobe),
        .i_wr_data   (i_wr_data),
        .i_rd0       (i_rd0),
        .i_rd1       (i_rd1),
        .o_rd_data0  (o_rd_data0),
        .o_rd_data1  (o_rd_data1),
        .o_latched   (o_latched)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int lat_cnt  = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a snapshot of each pad plus the number of reads
    // consumed since it was taken. Strobe high means "snapshot is live, count 0".
    bit         m_strobe = 1'b0;
    logic [7:0] m_snap0  = 8'hFF;
    logic [7:0] m_snap1  = 8'hFF;
    int         m_k0     = 8;
    int         m_k1     = 8;
    logic       m_lat    = 1'b0;

    function automatic logic exp_bit(input logic [7:0] snap, input int k);
        return (k < 8) ? snap[k] : FILL;
    endfunction

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_strobe = 1'b0;
            m_k0     = 8;
            m_k1     = 8;
            m_lat    = 1'b0;
        end else begin
            m_lat = i_wr_strobe && !i_wr_data && m_strobe;
            if (m_strobe) begin
                m_snap0 = i_btn0;
                m_snap1 = i_btn1;
                m_k0    = 0;
                m_k1    = 0;
            end else begin
                if (i_rd0 && !(i_wr_strobe && i_wr_data) && m_k0 < 8) m_k0++;
                if (i_rd1 && !(i_wr_strobe && i_wr_data) && m_k1 < 8) m_k1++;
            end
            if (i_wr_strobe) m_strobe = i_wr_data;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("model_port0", o_rd_data0, exp_bit(m_snap0, m_k0));
            chk("model_port1", o_rd_data1, exp_bit(m_snap1, m_k1));
            chk("model_latched", o_latched, m_lat);
            if (o_latched === 1'b1) lat_cnt++;
        end
    end

    // Drive one cycle's bus inputs just after the falling edge.
    task automatic drive(input logic wr, input logic wd, input logic r0, input logic r1);
        @(negedge i_clk);
        i_wr_strobe = wr;
        i_wr_data   = wd;
        i_rd0       = r0;
        i_rd1       = r1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Read cycle with literal expectations of the pre-shift bits.
    task automatic rd_chk(input string name, input logic r0, input logic r1,
                          input logic e0, input logic e1,
                          input logic wr, input logic wd);
        drive(wr, wd, r0, r1);
        #1;
        if (r0) chk({name, "_p0"}, o_rd_data0, e0);
        if (r1) chk({name, "_p1"}, o_rd_data1, e1);
    endtask

    task automatic latch_pads();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    initial begin
        logic [9:0] seq;
        logic [7:0] s0;
        logic [7:0] s1;
        int lat_before;

        // Reset state
        @(posedge i_clk);
        cmp_en = 1'b1;
        @(negedge i_clk);
        chk("reset_rd0", o_rd_data0, 1'b1);
        chk("reset_rd1", o_rd_data1, 1'b1);
        chk("reset_latched", o_latched, 1'b0);
        i_reset = 1'b0;

        // 1: no strobe, 10 reads return the fill bit
        for (int i = 0; i < 10; i++) rd_chk("t1_read", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_int("t1_no_latch", lat_cnt, 0);

        // 2: R,Select,A then 10 reads -> A-first order, then saturating fill
        i_btn0 = 8'b1000_0101;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        seq = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) rd_chk("t2_read", 1'b1, 1'b0, seq[i], 1'b0, 1'b0, 1'b0);
        idle();
        chk_int("t2_one_latch", lat_cnt, 1);

        // 3: strobe held high, A toggles every 3 cycles; reads follow A one cycle late
        i_btn0 = 8'h00;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            i_wr_strobe = 1'b0;
            i_btn0[0]   = 1'(((i / 3) % 2));
            i_rd0       = (i % 3 == 2);
            if (i_rd0) begin
                #1;
                chk("t3_live_a", o_rd_data0, 1'(((i - 1) / 3) % 2));
            end
        end
        idle();

        // 4: coincident reads on both ports
        i_btn0 = 8'h01;
        i_btn1 = 8'h80;
        drive(1'b1, 1'b0, 1'b0, 1'b0);   // falling edge of the held strobe
        s0 = 8'b0000_0001;
        s1 = 8'b1000_0000;
        for (int i = 0; i < 8; i++) rd_chk("t4_both", 1'b1, 1'b1, s0[i], s1[i], 1'b0, 1'b0);
        idle();

        // 5: 0-write with read while strobe low still shifts; 1-write with read does not
        i_btn0 = 8'b0101_1010;
        latch_pads();
        lat_before = lat_cnt;
        rd_chk("t5_r1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk("t5_r2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_chk("t5_r3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_chk("t5_r4_wr0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rd_chk("t5_r5_wr1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        #1;
        chk("t5_no_shift", o_rd_data0, 1'b1);
        chk_int("t5_no_latch", lat_cnt, lat_before + 1);  // only the latch_pads pulse
        idle();
        #1;
        chk("t5_reload_a", o_rd_data0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // 6: reset mid-sequence, then a fresh strobe restores A-first order
        i_btn0 = 8'b1000_0101;
        latch_pads();
        seq = 10'b00_0000_0101;
        for (int i = 0; i < 4; i++) rd_chk("t6_pre", 1'b1, 1'b0, seq[i], 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rd0   = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        rd_chk("t6_fill_a", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_chk("t6_fill_b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        latch_pads();
        for (int i = 0; i < 8; i++) rd_chk("t6_post", 1'b1, 1'b0, i_btn0[i], 1'b0, 1'b0, 1'b0);
        rd_chk("t6_post_fill", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
